// File: rtl/w5300_socket_arbiter.sv
// Round-robin arbiter sharing one W5300 access port among NUM_CH socket engines, with a per-access timeout.
// Optional statistics counters are built only when W5300_ARB_STATS_EN is defined.
module w5300_socket_arbiter #(
    parameter int CLK_FREQ       = 100,
    parameter int NUM_CH         = 4,
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            ch_req,
    input  logic [NUM_CH-1:0]            ch_we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wr_data,
    output logic [NUM_CH-1:0]            ch_done,
    output logic [NUM_CH-1:0]            ch_err,
    output logic [DATA_WIDTH-1:0]        ch_rd_data,
    output logic                         bus_req,
    output logic                         bus_we,
    output logic [ADDR_WIDTH-1:0]        bus_addr,
    output logic [DATA_WIDTH-1:0]        bus_wr_data,
    input  logic [DATA_WIDTH-1:0]        bus_rd_data,
    input  logic                         bus_done,
    output logic                         busy_n,
    output logic [NUM_CH*16-1:0]         stat_grant,
    output logic [15:0]                  stat_tmo
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_CH - 1);
    localparam logic [PTR_W:0]   NUM_CH_W = (PTR_W + 1)'(NUM_CH);

    if (NUM_CH < 1 || NUM_CH > 8 || TIMEOUT_CYCLES < 2 || CLK_FREQ < 1) begin : g_param_check
        $error("w5300_socket_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RELEASE
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;

    logic [ADDR_WIDTH-1:0] addr_arr [NUM_CH];
    logic [DATA_WIDTH-1:0] wdat_arr [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign addr_arr[i] = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdat_arr[i] = ch_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Rotate requests so bit 0 is the rr_ptr channel; the lowest set bit is then the winner.
    logic [NUM_CH-1:0] req_rot;
    logic [PTR_W-1:0]  pick_off;
    logic [PTR_W:0]    pick_sum;
    logic [PTR_W-1:0]  pick_idx;
    logic              pick_valid;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        req_rot    = NUM_CH'({ch_req, ch_req} >> rr_ptr);
        pick_off   = '0;
        pick_valid = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                pick_valid = 1'b1;
                pick_off   = PTR_W'(k);
            end
        end
        pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
        if (pick_sum >= NUM_CH_W) begin
            pick_sum = pick_sum - NUM_CH_W;
        end
        pick_idx = pick_sum[PTR_W-1:0];
    end

    // bus_done in the terminal count cycle takes priority over the timeout.
    assign tmo_hit = (state == ISSUE) && !bus_done && (tmo_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            gnt_idx     <= '0;
            tmo_cnt     <= '0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            ch_done     <= '0;
            ch_err      <= '0;
            ch_rd_data  <= '0;
            busy_n      <= 1'b1;
        end else begin
            ch_done <= '0;
            ch_err  <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_idx     <= pick_idx;
                        bus_we      <= ch_we[pick_idx];
                        bus_addr    <= addr_arr[pick_idx];
                        bus_wr_data <= wdat_arr[pick_idx];
                        bus_req     <= 1'b1;
                        busy_n      <= 1'b0;
                        tmo_cnt     <= '0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus_done) begin
                        bus_req    <= 1'b0;
                        ch_done    <= NUM_CH'(1) << gnt_idx;
                        ch_rd_data <= bus_rd_data;
                        state      <= RELEASE;
                    end else if (tmo_hit) begin
                        bus_req    <= 1'b0;
                        ch_done    <= NUM_CH'(1) << gnt_idx;
                        ch_err     <= NUM_CH'(1) << gnt_idx;
                        ch_rd_data <= '0;
                        state      <= RELEASE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    rr_ptr <= (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
                    busy_n <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef W5300_ARB_STATS_EN
    logic [15:0] grant_cnt [NUM_CH];
    logic [15:0] tmo_total;

    // NOTE: the counter array is reset explicitly; it is a register file, not RAM, and must read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                grant_cnt[i] <= '0;
            end
            tmo_total <= '0;
        end else begin
            if (state == IDLE && pick_valid && grant_cnt[pick_idx] != 16'hFFFF) begin
                grant_cnt[pick_idx] <= grant_cnt[pick_idx] + 16'd1;
            end
            if (tmo_hit && tmo_total != 16'hFFFF) begin
                tmo_total <= tmo_total + 16'd1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_stat
        assign stat_grant[i*16 +: 16] = grant_cnt[i];
    end
    assign stat_tmo = tmo_total;
`else
    assign stat_grant = '0;
    assign stat_tmo   = '0;
`endif

endmodule

// File: tb/tb_w5300_socket_arbiter.sv
// Self-checking bench for w5300_socket_arbiter: vector table, hand-written corner sequences and
// randomized transactions against a transaction-level round-robin model.
module tb_w5300_socket_arbiter;

    localparam int N   = 4;
    localparam int AW  = 12;
    localparam int DW  = 16;
    localparam int TMO = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    ch_req = '0;
    logic [N-1:0]    ch_we = '0;
    logic [N*AW-1:0] ch_addr = '0;
    logic [N*DW-1:0] ch_wr_data = '0;
    logic [N-1:0]    ch_done;
    logic [N-1:0]    ch_err;
    logic [DW-1:0]   ch_rd_data;
    logic            bus_req;
    logic            bus_we;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_wr_data;
    logic [DW-1:0]   bus_rd_data = '0;
    logic            bus_done = 1'b0;
    logic            busy_n;
    logic [N*16-1:0] stat_grant;
    logic [15:0]     stat_tmo;

    w5300_socket_arbiter #(
        .CLK_FREQ(100), .NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
        .ch_wr_data(ch_wr_data), .ch_done(ch_done), .ch_err(ch_err), .ch_rd_data(ch_rd_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_done(bus_done), .busy_n(busy_n),
        .stat_grant(stat_grant), .stat_tmo(stat_tmo)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Reference model state: transaction-level, not cycle-level.
    int model_ptr = 0;
    int model_grants [N];
    int model_tmo = 0;

    logic [AW-1:0] a_arr  [N];
    logic          we_arr [N];
    logic [DW-1:0] wd_arr [N];

    typedef struct {
        logic [N-1:0] req;
        int           delay;   // ISSUE cycle carrying bus_done; outside 0..TMO-1 means never
        logic [DW-1:0] rd;
        int           exp_g;
        logic         exp_err;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] req);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (model_ptr + k) % N;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        model_ptr = 0;
        model_tmo = 0;
        for (int i = 0; i < N; i++) model_grants[i] = 0;
    endtask

    task automatic pack_fields();
        for (int i = 0; i < N; i++) begin
            ch_addr[i*AW +: AW]    = a_arr[i];
            ch_we[i]               = we_arr[i];
            ch_wr_data[i*DW +: DW] = wd_arr[i];
        end
    endtask

    task automatic random_fields();
        for (int i = 0; i < N; i++) begin
            a_arr[i]  = AW'($urandom);
            we_arr[i] = 1'($urandom_range(0, 1));
            wd_arr[i] = DW'($urandom);
        end
        pack_fields();
    endtask

    task automatic check_stats();
        for (int i = 0; i < N; i++) begin
`ifdef W5300_ARB_STATS_EN
            check("stat_grant", stat_grant[i*16 +: 16], model_grants[i]);
`else
            check("stat_grant", stat_grant[i*16 +: 16], 0);
`endif
        end
`ifdef W5300_ARB_STATS_EN
        check("stat_tmo", stat_tmo, model_tmo);
`else
        check("stat_tmo", stat_tmo, 0);
`endif
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_bus_req"}, bus_req, 0);
        check({tag, "_busy_n"}, busy_n, 1);
        check({tag, "_ch_done"}, ch_done, 0);
        check({tag, "_ch_err"}, ch_err, 0);
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT back in IDLE.
    task automatic run_txn(input logic [N-1:0] req, input int delay, input logic [DW-1:0] rd,
                           output int obs_g, output logic obs_err);
        int            g;
        int            last;
        int            req_hi;
        logic          err;
        logic [AW-1:0] ea;
        logic          ewe;
        logic [DW-1:0] ewd;
        obs_g   = -1;
        obs_err = 1'b0;
        ch_req  = req;
        g = model_pick(req);
        if (g < 0) begin
            bus_done = 1'($urandom_range(0, 1));
            @(negedge clk);
            bus_done = 1'b0;
            check_idle("noreq");
            return;
        end
        ea  = a_arr[g];
        ewe = we_arr[g];
        ewd = wd_arr[g];
        err    = !(delay >= 0 && delay < TMO);
        last   = err ? TMO - 1 : delay;
        req_hi = 0;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            if (bus_req === 1'b1) req_hi++;
            check("issue_busy_n", busy_n, 0);
            check("issue_ch_done", ch_done, 0);
            check("bus_addr", bus_addr, ea);
            check("bus_we", bus_we, ewe);
            check("bus_wr_data", bus_wr_data, ewd);
            // Requests and channel fields changing mid-access must not disturb the latched access.
            ch_req = N'($urandom);
            random_fields();
            bus_done    = (c == delay);
            bus_rd_data = (c == delay) ? rd : DW'($urandom);
        end
        @(negedge clk);
        bus_done = 1'b0;
        check("bus_req_cycles", req_hi, last + 1);
        check("release_bus_req", bus_req, 0);
        check("release_busy_n", busy_n, 0);
        check("ch_done", ch_done, 1 << g);
        check("ch_err", ch_err, err ? (1 << g) : 0);
        check("ch_rd_data", ch_rd_data, err ? 0 : rd);
        for (int i = 0; i < N; i++) if (ch_done[i]) obs_g = i;
        obs_err = |ch_err;
        model_grants[g]++;
        if (err) model_tmo++;
        model_ptr = (g + 1) % N;
        ch_req   = N'($urandom);
        bus_done = 1'($urandom_range(0, 1));
        @(negedge clk);
        bus_done = 1'b0;
        ch_req   = '0;
        check_idle("after");
        check_stats();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ch_req = '0;
        bus_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int   g;
        logic e;
        int   exp_order [5];

        vecs[0] = '{req: 4'b0010, delay: 3,  rd: 16'h1234, exp_g: 1, exp_err: 1'b0};
        vecs[1] = '{req: 4'b1111, delay: 0,  rd: 16'hA001, exp_g: 2, exp_err: 1'b0};
        vecs[2] = '{req: 4'b1111, delay: 1,  rd: 16'hA002, exp_g: 3, exp_err: 1'b0};
        vecs[3] = '{req: 4'b1111, delay: 2,  rd: 16'hA003, exp_g: 0, exp_err: 1'b0};
        vecs[4] = '{req: 4'b1111, delay: 0,  rd: 16'hA004, exp_g: 1, exp_err: 1'b0};
        vecs[5] = '{req: 4'b1111, delay: 0,  rd: 16'hA005, exp_g: 2, exp_err: 1'b0};
        vecs[6] = '{req: 4'b0001, delay: 7,  rd: 16'h5A5A, exp_g: 0, exp_err: 1'b0};
        vecs[7] = '{req: 4'b1000, delay: -1, rd: 16'hFFFF, exp_g: 3, exp_err: 1'b1};
        vecs[8] = '{req: 4'b1001, delay: 1,  rd: 16'h0F0F, exp_g: 0, exp_err: 1'b0};
        vecs[9] = '{req: 4'b0001, delay: 0,  rd: 16'h3C3C, exp_g: 0, exp_err: 1'b0};
        exp_order = '{0, 1, 2, 3, 0};

        model_reset();
        random_fields();

        // Reset state.
        #12;
        check_idle("reset");
        check("reset_rd_data", ch_rd_data, 0);
        check("reset_bus_addr", bus_addr, 0);
        check_stats();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table.
        for (int v = 0; v < 10; v++) begin
            random_fields();
            if (v == 0) begin
                a_arr[1]  = 12'h208;
                we_arr[1] = 1'b0;
                pack_fields();
            end
            run_txn(vecs[v].req, vecs[v].delay, vecs[v].rd, g, e);
            check("vec_grant", g, vecs[v].exp_g);
            check("vec_err", e, vecs[v].exp_err);
        end

        // All channels requesting from reset: strict rotation 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            random_fields();
            run_txn(4'b1111, i % 3, DW'($urandom), g, e);
            check("rr_order", g, exp_order[i]);
        end

        // Reset in the middle of an access aborts it and restarts arbitration at channel 0.
        ch_req = 4'b0100;
        @(negedge clk);
        check("pre_reset_bus_req", bus_req, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("mid_reset");
        check("mid_reset_bus_addr", bus_addr, 0);
        ch_req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_done = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_done = 1'b0;
            check_idle("post_reset");
        end
        check_stats();
        random_fields();
        run_txn(4'b1111, 1, 16'hBEEF, g, e);
        check("post_reset_grant", g, 0);

        // Randomized transactions against the model.
        for (int t = 0; t < 60; t++) begin
            int d;
            d = int'($urandom_range(0, 10));
            if (d == 10) d = -1;
            random_fields();
            run_txn(N'($urandom), d, DW'($urandom), g, e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
